i2c_target_regs: RTL and testbench

Synthesizable I2C target (slave) with a small byte-addressable register file. It sits on the `scl`/`sda` bus opposite the iicmb I2C controller, so the controller can be exercised against real RTL and not only the behavioural slave model. It answers one fixed 7-bit address, supports pointer-based writes and reads with auto-increment, and exposes every register write and a debug read port to the local side.

---
 rtl/i2c_target_regs.sv | 244 ++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target answering one 7-bit address and fronting a small
// byte-wide register file. The first written byte sets the register pointer.
// Later written bytes are stored at the pointer. Reads stream out from the
// pointer. The pointer auto-increments and wraps in both directions.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR       = 7'h22,
  parameter int         REG_ADDR_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic                      busy_o,
  output logic                      wr_stb_o,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [7:0]                wr_data_o,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [7:0]                dbg_data_o
);

  localparam int DEPTH = 1 << REG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_WAIT
  } state_t;

  state_t                    state, state_n;
  logic [2:0]                scl_sr, sda_sr;   // [0],[1] synchronizer, [2] edge-detect history
  logic [3:0]                bit_cnt, bit_cnt_n;
  logic [7:0]                shreg, shreg_n;
  logic                      phase, phase_n;   // ACK slot: 0 = waiting to drive, 1 = driving
  logic                      rw, rw_n;
  logic                      first_byte, first_n;
  logic [REG_ADDR_WIDTH-1:0] ptr, ptr_n;
  logic                      sda_n, busy_n, wr_stb_n, reg_we;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_n;
  logic [7:0]                wr_data_n;
  logic [7:0]                regs [DEPTH];
  logic [7:0]                byte_in, rd_byte;
  logic                      scl_s, scl_d, sda_s, sda_d;
  logic                      scl_rise, scl_fall, start_det, stop_det;

  assign scl_o = 1'b1;

  assign scl_s = scl_sr[1];
  assign scl_d = scl_sr[2];
  assign sda_s = sda_sr[1];
  assign sda_d = sda_sr[2];

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_in    = {shreg[6:0], sda_s};
  assign rd_byte    = regs[ptr];
  assign dbg_data_o = regs[dbg_addr_i];

  // Bring the bus lines into the clk_i domain and keep one cycle of history for edges.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_i};
      sda_sr <= {sda_sr[1:0], sda_i};
    end
  end

  // Protocol state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      phase      <= 1'b0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      ptr        <= '0;
      sda_o      <= 1'b1;
      busy_o     <= 1'b0;
      wr_stb_o   <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      phase      <= phase_n;
      rw         <= rw_n;
      first_byte <= first_n;
      ptr        <= ptr_n;
      sda_o      <= sda_n;
      busy_o     <= busy_n;
      wr_stb_o   <= wr_stb_n;
      wr_addr_o  <= wr_addr_n;
      wr_data_o  <= wr_data_n;
    end
  end

  // Register file storage: cleared on reset, written by the I2C write path.
  // NOTE: the file is small and must read back 8'h00 after reset, so it uses
  // real reset flops rather than an unreset RAM.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[ptr] <= byte_in;
    end
  end

  // Next-state and datapath decode; START/STOP override every state.
  // NOTE: every signal gets a default first so no path leaves a latch behind.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    phase_n   = phase;
    rw_n      = rw;
    first_n   = first_byte;
    ptr_n     = ptr;
    sda_n     = sda_o;
    busy_n    = busy_o;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr_o;
    wr_data_n = wr_data_o;
    reg_we    = 1'b0;

    if (stop_det) begin
      state_n = ST_IDLE;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_n     = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: sda_n = 1'b1;

        ST_ADDR: if (scl_rise) begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (byte_in[7:1] == I2C_ADDR) begin
              state_n = ST_ADDR_ACK;
              rw_n    = byte_in[0];
              busy_n  = 1'b1;
              phase_n = 1'b0;
            end else begin
              state_n = ST_IDLE;
              busy_n  = 1'b0;
            end
          end
        end

        ST_ADDR_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_n   = 1'b0;
            phase_n = 1'b1;
          end else begin
            phase_n   = 1'b0;
            bit_cnt_n = '0;
            if (rw) begin
              state_n = ST_RD_BYTE;
              sda_n   = rd_byte[7];
              shreg_n = {rd_byte[6:0], 1'b0};
            end else begin
              state_n = ST_WR_BYTE;
              sda_n   = 1'b1;
              first_n = 1'b1;
            end
          end
        end

        ST_WR_BYTE: if (scl_rise) begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_n = ST_WR_ACK;
            phase_n = 1'b0;
            if (first_byte) begin
              ptr_n   = byte_in[REG_ADDR_WIDTH-1:0];
              first_n = 1'b0;
            end else begin
              reg_we    = 1'b1;
              wr_stb_n  = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = byte_in;
              ptr_n     = ptr + 1'b1;
            end
          end
        end

        ST_WR_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_n   = 1'b0;
            phase_n = 1'b1;
          end else begin
            sda_n     = 1'b1;
            phase_n   = 1'b0;
            bit_cnt_n = '0;
            state_n   = ST_WR_BYTE;
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_n   = 1'b1;
              state_n = ST_RD_ACK;
              ptr_n   = ptr + 1'b1;
              phase_n = 1'b0;
            end else begin
              sda_n   = shreg[7];
              shreg_n = {shreg[6:0], 1'b0};
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_n = ST_WAIT;
            else       phase_n = 1'b1;
          end else if (scl_fall && phase) begin
            state_n   = ST_RD_BYTE;
            phase_n   = 1'b0;
            bit_cnt_n = '0;
            sda_n     = rd_byte[7];
            shreg_n   = {rd_byte[6:0], 1'b0};
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: the bench acts as the I2C controller on a
// wired-AND bus and checks ACKs, read data, write strobes and debug reads.
module tb_i2c_target_regs;

  localparam int Q = 8;   // clk cycles per quarter SCL period (32 clk per bit)

  logic       clk, rst_n;
  logic       scl_m, sda_m;
  logic       scl_o, sda_o, busy_o, wr_stb_o;
  logic [3:0] wr_addr_o, dbg_addr;
  logic [7:0] wr_data_o, dbg_data_o;
  logic       scl_bus, sda_bus;

  int tests_run = 0;
  int tests_failed = 0;

  // write-strobe monitor
  int         stb_cnt = 0;
  logic [3:0] stb_addr [16];
  logic [7:0] stb_data [16];
  logic [7:0] stb_dbg_old [16];
  logic [7:0] stb_dbg_new [16];
  logic [7:0] dbg_prev = 8'h00;
  logic       sda_low_seen = 1'b0;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  i2c_target_regs #(.I2C_ADDR(7'h22), .REG_ADDR_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .busy_o(busy_o), .wr_stb_o(wr_stb_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb_o && stb_cnt < 16) begin
      stb_addr[stb_cnt]    = wr_addr_o;
      stb_data[stb_cnt]    = wr_data_o;
      stb_dbg_old[stb_cnt] = dbg_prev;
      stb_dbg_new[stb_cnt] = dbg_data_o;
      stb_cnt++;
    end
    if (!sda_o) sda_low_seen = 1'b1;
    dbg_prev = dbg_data_o;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({scl_o, sda_o, busy_o, wr_stb_o} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_ctl: got scl/sda/busy/stb=%b want 1100", {scl_o, sda_o, busy_o, wr_stb_o});
    end
    tests_run++;
    if ({wr_addr_o, wr_data_o} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_wr: got addr=%h data=%h want 0/00", wr_addr_o, wr_data_o);
    end
    for (int i = 0; i < 16; i += 5) begin
      dbg_addr = 4'(i); #1;
      tests_run++;
      if (dbg_data_o !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_reg%0d: got %h want 00", i, dbg_data_o);
      end
    end
  endtask

  task automatic test_write();
    logic [3:0] acks;
    logic a;
    stb_cnt  = 0;
    dbg_addr = 4'd6;
    i2c_start();
    send_byte(8'h44, a); acks[3] = a;
    send_byte(8'h05, a); acks[2] = a;
    send_byte(8'h44, a); acks[1] = a;
    send_byte(8'h78, a); acks[0] = a;
    tests_run++;
    if (acks !== 4'b0000) begin
      tests_failed++;
      $display("FAIL write_acks: got %b want 0000", acks);
    end
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_busy_mid: got %b want 1", busy_o);
    end
    i2c_stop();
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_busy_stop: got %b want 0", busy_o);
    end
    tests_run++;
    if (stb_cnt != 2) begin
      tests_failed++;
      $display("FAIL write_stb_cnt: got %0d want 2", stb_cnt);
    end else begin
      tests_run++;
      if ({stb_addr[0], stb_data[0], stb_addr[1], stb_data[1]} !== {4'd5, 8'h44, 4'd6, 8'h78}) begin
        tests_failed++;
        $display("FAIL write_stb_vals: got (%0d,%h)(%0d,%h) want (5,44)(6,78)",
                 stb_addr[0], stb_data[0], stb_addr[1], stb_data[1]);
      end
      tests_run++;
      if ({stb_dbg_old[1], stb_dbg_new[1]} !== {8'h00, 8'h78}) begin
        tests_failed++;
        $display("FAIL write_dbg_same_cycle: got old=%h new=%h want 00/78", stb_dbg_old[1], stb_dbg_new[1]);
      end
    end
    dbg_addr = 4'd5; #1;
    tests_run++;
    if (dbg_data_o !== 8'h44) begin
      tests_failed++;
      $display("FAIL write_reg5: got %h want 44", dbg_data_o);
    end
    dbg_addr = 4'd6; #1;
    tests_run++;
    if (dbg_data_o !== 8'h78) begin
      tests_failed++;
      $display("FAIL write_reg6: got %h want 78", dbg_data_o);
    end
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] d0, d1, d2;
    logic [2:0] acks;
    // preload reg3=A5, reg4=3C
    i2c_start();
    send_byte(8'h44, a); send_byte(8'h03, a); send_byte(8'hA5, a); send_byte(8'h3C, a);
    i2c_stop();
    i2c_start();
    send_byte(8'h44, a); acks[2] = a;
    send_byte(8'h03, a); acks[1] = a;
    i2c_start();
    send_byte(8'h45, a); acks[0] = a;
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    tests_run++;
    if (acks !== 3'b000) begin
      tests_failed++;
      $display("FAIL read_acks: got %b want 000", acks);
    end
    tests_run++;
    if ({d0, d1} !== {8'hA5, 8'h3C}) begin
      tests_failed++;
      $display("FAIL read_data: got %h %h want a5 3c", d0, d1);
    end
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_busy_wait: got %b want 1", busy_o);
    end
    i2c_stop();
    // pointer left at 5: a bare read returns reg5 (0x44 from the write test)
    i2c_start();
    send_byte(8'h45, a);
    recv_byte(1'b1, d2);
    i2c_stop();
    tests_run++;
    if (d2 !== 8'h44) begin
      tests_failed++;
      $display("FAIL read_ptr5: got %h want 44", d2);
    end
  endtask

  task automatic test_mismatch();
    logic [3:0] acks;
    logic a;
    stb_cnt = 0;
    sda_low_seen = 1'b0;
    i2c_start();
    send_byte(8'h46, a); acks[3] = a;
    send_byte(8'h01, a); acks[2] = a;
    send_byte(8'h00, a); acks[1] = a;
    send_byte(8'hFF, a); acks[0] = a;
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mismatch_busy: got %b want 0", busy_o);
    end
    i2c_stop();
    tests_run++;
    if ({acks, sda_low_seen} !== 5'b11110) begin
      tests_failed++;
      $display("FAIL mismatch_sda: got acks=%b low_seen=%b want 1111/0", acks, sda_low_seen);
    end
    tests_run++;
    if (stb_cnt != 0) begin
      tests_failed++;
      $display("FAIL mismatch_stb: got %0d strobes want 0", stb_cnt);
    end
  endtask

  task automatic test_wrap();
    logic a;
    stb_cnt = 0;
    i2c_start();
    send_byte(8'h44, a); send_byte(8'h0F, a); send_byte(8'h11, a); send_byte(8'h22, a);
    i2c_stop();
    tests_run++;
    if (stb_cnt != 2 || {stb_addr[0], stb_data[0], stb_addr[1], stb_data[1]} !== {4'd15, 8'h11, 4'd0, 8'h22}) begin
      tests_failed++;
      $display("FAIL wrap_stb: got n=%0d (%0d,%h)(%0d,%h) want (15,11)(0,22)",
               stb_cnt, stb_addr[0], stb_data[0], stb_addr[1], stb_data[1]);
    end
    dbg_addr = 4'd15; #1;
    tests_run++;
    if (dbg_data_o !== 8'h11) begin
      tests_failed++;
      $display("FAIL wrap_reg15: got %h want 11", dbg_data_o);
    end
    dbg_addr = 4'd0; #1;
    tests_run++;
    if (dbg_data_o !== 8'h22) begin
      tests_failed++;
      $display("FAIL wrap_reg0: got %h want 22", dbg_data_o);
    end
  endtask

  task automatic test_abort();
    logic a, a2, a3;
    stb_cnt = 0;
    // STOP after four data bits: nothing stored
    i2c_start();
    send_byte(8'h44, a); send_byte(8'h07, a);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    dbg_addr = 4'd7; #1;
    tests_run++;
    if (stb_cnt != 0 || dbg_data_o !== 8'h00 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_stop: got stb=%0d reg7=%h busy=%b want 0/00/0", stb_cnt, dbg_data_o, busy_o);
    end
    // reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(a == 1'b0 ? 8'h44 >> i : 8'h44 >> i);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    tests_run++;
    if (sda_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ack_drive: got sda_o=%b want 0", sda_o);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (sda_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_reset_release: got sda_o=%b want 1", sda_o);
    end
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2*Q);
    stb_cnt = 0;
    i2c_start();
    send_byte(8'h44, a); send_byte(8'h02, a2); send_byte(8'h99, a3);
    i2c_stop();
    dbg_addr = 4'd2; #1;
    tests_run++;
    if ({a, a2, a3} !== 3'b000 || stb_cnt != 1 || dbg_data_o !== 8'h99) begin
      tests_failed++;
      $display("FAIL abort_recover: got acks=%b stb=%0d reg2=%h want 000/1/99", {a, a2, a3}, stb_cnt, dbg_data_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; dbg_addr = 4'd0;
    wait_clk(3);
    #2;
    test_reset();
    rst_n = 1'b1;
    wait_clk(2*Q);
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
